// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared line geometry, refill state type and AXI encodings for the icache refill path
package icache_pkg;

  localparam int LINE_BITS      = 512;
  localparam int TAG_BITS       = 52;
  localparam int INDEX_BITS     = 6;
  localparam int WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_FILL
  } refill_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP = 2'd2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'd0;

endpackage

// File: rtl/icache_line_assembler.sv
// rtl/icache_line_assembler.sv - slots 64b read beats into a 512b line at (start_word + beat_cnt) mod 8
module icache_line_assembler
  import icache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           start_word,
  input  logic                 beat_valid,
  input  logic [63:0]          beat_data,
  output logic [2:0]           beat_cnt,
  output logic [LINE_BITS-1:0] line_data
);

  logic [2:0] slot;

  // 3-bit add wraps naturally, which gives the WRAP-burst word order for free
  assign slot = start_word + beat_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_cnt <= '0;
    end else if (start) begin
      beat_cnt <= '0;
    end else if (beat_valid) begin
      beat_cnt <= beat_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_valid) begin
      line_data[{slot, 6'b0} +: 64] <= beat_data;
    end
  end

endmodule

// File: rtl/icache_refill_unit.sv
// rtl/icache_refill_unit.sv - single-outstanding icache miss refill over AXI; ICACHE_REFILL_CRITICAL_WORD_FIRST_EN enables wrap bursts
module icache_refill_unit
  import icache_pkg::*;
#(
  parameter int                  ID_WIDTH   = 13,
  parameter int                  ADDR_WIDTH = 64,
  parameter int                  DATA_WIDTH = 64,
  parameter logic [ID_WIDTH-1:0] REFILL_ID  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  fill_valid,
  output logic [INDEX_BITS-1:0] fill_index,
  output logic [TAG_BITS-1:0]   fill_tag,
  output logic [LINE_BITS-1:0]  fill_line,
  output logic                  fill_error,
  output logic                  crit_valid,
  output logic [DATA_WIDTH-1:0] crit_data
);

  refill_state_t         state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rdy_q, err_q;
  logic                  accept, r_hs, last_beat, beat_err;
  logic [2:0]            beat_cnt, start_word;

  assign accept    = miss_valid && rdy_q;
  assign r_hs      = (state == ST_R) && m_rvalid;
  assign last_beat = m_rlast || (beat_cnt == 3'd7);
  // a beat is bad if its response/ID is wrong or rlast disagrees with beat 7
  assign beat_err  = (m_rresp != AXI_RESP_OKAY) || (m_rid != REFILL_ID) ||
                     (m_rlast != (beat_cnt == 3'd7));

  always_comb begin
    state_nxt  = state;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    fill_valid = 1'b0;
    fill_error = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_AR;
      ST_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = ST_R;
      end
      ST_R: begin
        m_rready = 1'b1;
        if (m_rvalid && last_beat) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        fill_valid = 1'b1;
        fill_error = err_q;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // miss_ready is registered so it stays low for the first cycle out of reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == ST_IDLE);
      if (accept) begin
        err_q <= 1'b0;
      end else if (r_hs && beat_err) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) addr_q <= miss_addr;
  end

  assign miss_ready = rdy_q;
  assign m_arid     = REFILL_ID;
  assign m_arlen    = 8'd7;
  assign m_arsize   = 3'd3;
  assign fill_index = addr_q[11:6];
  assign fill_tag   = addr_q[ADDR_WIDTH-1 -: TAG_BITS];

  icache_line_assembler u_assembler (
    .clk        (clk),
    .reset      (reset),
    .start      (accept),
    .start_word (start_word),
    .beat_valid (r_hs),
    .beat_data  (m_rdata),
    .beat_cnt   (beat_cnt),
    .line_data  (fill_line)
  );

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic crit_q;
  logic [DATA_WIDTH-1:0] crit_d;
  logic unused_addr;

  assign m_araddr    = {addr_q[ADDR_WIDTH-1:3], 3'b0};
  assign m_arburst   = AXI_BURST_WRAP;
  assign start_word  = addr_q[5:3];
  assign unused_addr = ^addr_q[2:0];

  always_ff @(posedge clk) begin
    if (!reset) crit_q <= 1'b0;
    else        crit_q <= r_hs && (beat_cnt == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (r_hs && (beat_cnt == 3'd0)) crit_d <= m_rdata;
  end

  assign crit_valid = crit_q;
  assign crit_data  = crit_d;
`else
  logic unused_addr;

  assign m_araddr    = {addr_q[ADDR_WIDTH-1:6], 6'b0};
  assign m_arburst   = AXI_BURST_INCR;
  assign start_word  = 3'd0;
  assign unused_addr = ^addr_q[5:0];
  assign crit_valid  = 1'b0;
  assign crit_data   = '0;
`endif

endmodule
